// File: rtl/relay_arbiter_if.sv
// Demodulator/encoder side signals of the relay arbiter.
// master = front ends + encoder, slave = arbiter.
interface relay_arbiter_if;
    logic reader_req;
    logic tag_req;
    logic enc_out;
    logic mode;
    logic enc_reset;
    logic sel_tag;

    modport master (
        output reader_req, tag_req, enc_out,
        input  mode, enc_reset, sel_tag
    );

    modport slave (
        input  reader_req, tag_req, enc_out,
        output mode, enc_reset, sel_tag
    );
endinterface

// File: rtl/relay_arbiter.sv
// Direction arbiter time-sharing one relay encoder between reader and tag.
// Define RELAY_ARB_PREEMPT_EN to let reader activity cut a TAG phase short.
module relay_arbiter #(
    parameter int GUARD_CYCLES   = 64,
    parameter int IDLE_TIMEOUT   = 1024,
    parameter int MAX_TAG_CYCLES = 4096
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    relay_arbiter_if.slave bus,
    output logic           active,
    output logic [2:0]     state,
    output logic           err_collision,
    output logic           err_spurious
);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam int TW = $clog2(MAX_TAG_CYCLES);

    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LD  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] TAG_LD   = TW'(MAX_TAG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READER   = 3'd1,
        S_TURN_R2T = 3'd2,
        S_TAG      = 3'd3,
        S_TURN_T2R = 3'd4
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [IW-1:0] idle_cnt;
    logic [GW-1:0] guard_cnt;
    logic [TW-1:0] tag_cnt;

    logic rd_act;
    logic tg_act;
    logic idle_exp_rd;
    logic idle_exp_tg;
    logic guard_done;
    logic tag_exp;
    logic preempt;
    logic to_tag;
    logic turn;

    assign state = cur;

    always_comb begin
        rd_act      = bus.reader_req | bus.enc_out;
        tg_act      = bus.tag_req | bus.enc_out;
        idle_exp_rd = !rd_act && (idle_cnt == '0);
        idle_exp_tg = !tg_act && (idle_cnt == '0);
        guard_done  = (guard_cnt == '0);
        tag_exp     = (tag_cnt == '0);
`ifdef RELAY_ARB_PREEMPT_EN
        preempt     = bus.reader_req;
`else
        preempt     = 1'b0;
`endif
    end

    always_comb begin
        nxt = cur;
        if (!enable) begin
            nxt = S_IDLE;
        end else begin
            case (cur)
                S_IDLE:     if (bus.reader_req) nxt = S_READER;
                S_READER:   if (idle_exp_rd) nxt = S_TURN_R2T;
                S_TURN_R2T: if (guard_done) nxt = S_TAG;
                S_TAG:      if (idle_exp_tg || tag_exp || preempt)
                                nxt = S_TURN_T2R;
                S_TURN_T2R: if (guard_done) nxt = S_IDLE;
                default:    nxt = S_IDLE;
            endcase
        end
    end

    // Outputs decode the next state so they switch with the state register.
    always_comb begin
        to_tag = (nxt == S_TURN_R2T) || (nxt == S_TAG);
        turn   = (nxt == S_TURN_R2T) || (nxt == S_TURN_T2R);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur           <= S_IDLE;
            bus.mode      <= 1'b0;
            bus.sel_tag   <= 1'b0;
            bus.enc_reset <= 1'b1;
            active        <= 1'b0;
            err_collision <= 1'b0;
            err_spurious  <= 1'b0;
            idle_cnt      <= '0;
            guard_cnt     <= '0;
            tag_cnt       <= '0;
        end else begin
            cur           <= nxt;
            bus.mode      <= to_tag;
            bus.sel_tag   <= to_tag;
            bus.enc_reset <= !enable || turn;
            active        <= (nxt != S_IDLE);
            // While disabled, counters and sticky flags are frozen.
            if (enable) begin
                if (cur == S_IDLE && bus.tag_req && !bus.reader_req)
                    err_spurious <= 1'b1;
                if (cur == S_TAG && bus.reader_req)
                    err_collision <= 1'b1;
                if (nxt != cur) begin
                    case (nxt)
                        S_READER:   idle_cnt <= IDLE_LD;
                        S_TURN_R2T: guard_cnt <= GUARD_LD;
                        S_TURN_T2R: guard_cnt <= GUARD_LD;
                        S_TAG: begin
                            idle_cnt <= IDLE_LD;
                            tag_cnt  <= TAG_LD;
                        end
                        default: ;
                    endcase
                end else begin
                    case (cur)
                        S_READER:
                            idle_cnt <= rd_act ? IDLE_LD :
                                (idle_cnt != '0) ? idle_cnt - 1'b1 : '0;
                        S_TAG: begin
                            idle_cnt <= tg_act ? IDLE_LD :
                                (idle_cnt != '0) ? idle_cnt - 1'b1 : '0;
                            tag_cnt  <= (tag_cnt != '0) ? tag_cnt - 1'b1 : '0;
                        end
                        S_TURN_R2T, S_TURN_T2R:
                            guard_cnt <= (guard_cnt != '0) ? guard_cnt - 1'b1 : '0;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_relay_arbiter.sv
// Scoreboard bench for relay_arbiter.
// Default parameters, negedge monitor.
module tb_relay_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       active;
  logic [2:0] state;
  logic       err_collision;
  logic       err_spurious;

  relay_arbiter_if bus ();

  relay_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .bus           (bus),
    .active        (active),
    .state         (state),
    .err_collision (err_collision),
    .err_spurious  (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   pcyc  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic expect_at(input int dly,
                           input logic [2:0] st,
                           input logic r,
                           input logic ec,
                           input logic es,
                           input string nm);
    exp_t e;
    logic tg;
    tg    = (st == 3'd2) || (st == 3'd3);
    e.cyc = pcyc + dly;
    e.v   = {st, tg, tg, r, st != 3'd0, ec, es};
    e.nm  = nm;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [8:0] got;
    got = {state, bus.mode, bus.sel_tag,
           bus.enc_reset, active,
           err_collision, err_spurious};
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == pcyc) begin
        n_cmp++;
        if (got !== sbq[i].v) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got %b want %b",
                   sbq[i].nm, pcyc, got, sbq[i].v);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    enable         = 1'b1;
    bus.reader_req = 1'b0;
    bus.tag_req    = 1'b0;
    bus.enc_out    = 1'b0;
    expect_at(1, 3'd0, 1'b1, 1'b0, 1'b0, "reset");
    step(2);
    reset_n = 1'b1;
    expect_at(1, 3'd0, 1'b0, 1'b0, 1'b0, "release");
    step(3);
    n_cmp++;
    if (state !== 3'd0 || bus.enc_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL d_release: st=%0d er=%b",
               state, bus.enc_reset);
    end

    bus.reader_req = 1'b1;
    bus.tag_req    = 1'b1;
    expect_at(1, 3'd1, 1'b0, 1'b0, 1'b0, "simul");
    step(1);
    n_cmp++;
    if (state !== 3'd1 || err_spurious !== 1'b0) begin
      n_bad++;
      $display("FAIL d_simul: st=%0d es=%b",
               state, err_spurious);
    end
    bus.tag_req = 1'b0;
    step(9);
    bus.reader_req = 1'b0;
    expect_at(1023, 3'd1, 1'b0, 1'b0, 1'b0, "rd_last");
    expect_at(1024, 3'd2, 1'b1, 1'b0, 1'b0, "r2t_in");
    expect_at(1087, 3'd2, 1'b1, 1'b0, 1'b0, "r2t_last");
    expect_at(1088, 3'd3, 1'b0, 1'b0, 1'b0, "tag_in");
    step(1088);

    expect_at(4095, 3'd3, 1'b0, 1'b0, 1'b0, "tag_hold");
    expect_at(4096, 3'd4, 1'b1, 1'b0, 1'b0, "tmax");
    expect_at(4159, 3'd4, 1'b1, 1'b0, 1'b0, "t2r_last");
    expect_at(4160, 3'd0, 1'b0, 1'b0, 1'b0, "t2r_done");
    for (int i = 0; i < 41; i++) begin
      bus.tag_req = ~bus.tag_req;
      step(100);
    end
    bus.tag_req = 1'b0;
    step(62);

    bus.tag_req = 1'b1;
    expect_at(1, 3'd0, 1'b0, 1'b0, 1'b1, "spur");
    step(1);
    n_cmp++;
    if (state !== 3'd0 || err_spurious !== 1'b1) begin
      n_bad++;
      $display("FAIL d_spur: st=%0d es=%b",
               state, err_spurious);
    end
    bus.tag_req = 1'b0;
    step(2);

    bus.reader_req = 1'b1;
    expect_at(1, 3'd1, 1'b0, 1'b0, 1'b1, "rd2");
    step(1);
    bus.reader_req = 1'b0;
    bus.enc_out    = 1'b1;
    step(5);
    bus.enc_out = 1'b0;
    expect_at(1023, 3'd1, 1'b0, 1'b0, 1'b1, "enc_act");
    expect_at(1024, 3'd2, 1'b1, 1'b0, 1'b1, "r2t2");
    expect_at(1088, 3'd3, 1'b0, 1'b0, 1'b1, "tag2");
    step(1088);

    bus.reader_req = 1'b1;
`ifdef RELAY_ARB_PREEMPT_EN
    expect_at(1, 3'd4, 1'b1, 1'b1, 1'b1, "coll");
    expect_at(64, 3'd4, 1'b1, 1'b1, 1'b1, "coll_guard");
    expect_at(65, 3'd0, 1'b0, 1'b1, 1'b1, "coll_idle");
    step(1);
    bus.reader_req = 1'b0;
    step(66);
`else
    expect_at(1, 3'd3, 1'b0, 1'b1, 1'b1, "coll");
    expect_at(1023, 3'd3, 1'b0, 1'b1, 1'b1, "tidle_last");
    expect_at(1024, 3'd4, 1'b1, 1'b1, 1'b1, "tidle");
    expect_at(1088, 3'd0, 1'b0, 1'b1, 1'b1, "tidle_done");
    step(1);
    bus.reader_req = 1'b0;
    step(1089);
`endif

    bus.reader_req = 1'b1;
    step(1);
    bus.reader_req = 1'b0;
    expect_at(1088, 3'd3, 1'b0, 1'b1, 1'b1, "tag3");
    step(1093);
    enable = 1'b0;
    expect_at(1, 3'd0, 1'b1, 1'b1, 1'b1, "en_off");
    expect_at(3, 3'd0, 1'b1, 1'b1, 1'b1, "en_hold");
    step(3);
    n_cmp++;
    if (state !== 3'd0 || bus.enc_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL d_en_off: st=%0d er=%b",
               state, bus.enc_reset);
    end
    enable = 1'b1;
    expect_at(1, 3'd0, 1'b0, 1'b1, 1'b1, "en_on");
    step(3);

    bus.reader_req = 1'b1;
    expect_at(1, 3'd1, 1'b0, 1'b1, 1'b1, "rd4");
    step(1);
    bus.reader_req = 1'b0;
    step(2);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    expect_at(0, 3'd0, 1'b1, 1'b0, 1'b0, "arst");
    #1;
    n_cmp++;
    if (state !== 3'd0 || bus.enc_reset !== 1'b1 ||
        err_collision !== 1'b0) begin
      n_bad++;
      $display("FAIL d_arst: st=%0d er=%b ec=%b",
               state, bus.enc_reset, err_collision);
    end
    step(2);
    reset_n = 1'b1;
    expect_at(1, 3'd0, 1'b0, 1'b0, 1'b0, "post_rst");
    step(4);

    while (sbq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s expired: got none want %b",
               sbq[0].nm, sbq[0].v);
      sbq.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
